// File: rtl/mem_port_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arb_pkg
// Brief  : Shared types and helpers for the unified memory-port arbiter:
//          FSM state encoding, owner codes and counter width helper.
// Rev    : 1.0  initial release
// ============================================================================
package mem_port_arb_pkg;

    // Arbiter states (2-bit encoding)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Owner codes: which requester holds (or last held) the port
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    // Bits needed to hold values 0..max_val (never less than one bit)
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module : arb_sat_cnt
// Brief  : Saturating up-counter with synchronous clear and increment,
//          asynchronous active-low reset. Clear has priority over increment.
// Rev    : 1.0  initial release
// ============================================================================
module arb_sat_cnt #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] LIMIT_VAL = WIDTH'(LIMIT);

    // Count up on inc, hold at LIMIT, return to zero on clr
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT_VAL)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arb
// Brief  : Arbitrates the single memory port between instruction fetch and
//          data access. Data wins by default; a starvation counter forces an
//          instruction grant, and every bus transfer is bounded by a timeout.
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy,
    output logic          owner,
    output logic          err
);

    localparam int SW = cnt_width(STARVE_MAX);
    localparam int TW = cnt_width(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LIM    = TW'(TIMEOUT - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          grant_if;
    logic          grant_dm;
    logic          bus_done;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;

    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_wdata;
    logic          hold_we;
    logic          owner_q;
    logic          err_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;

    // State register; async reset drops any transfer in flight
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus grant/completion strobes
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        bus_done  = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && !(if_req && (starve_cnt == STARVE_LIM))) begin
                    grant_dm  = 1'b1;
                    state_nxt = BUS_D;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = BUS_I;
                end
            end
            BUS_I, BUS_D: begin
                if (mem_rdy || (tmo_cnt == TMO_LIM)) begin
                    bus_done  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Holding registers latched at grant; read data and err captured at bus exit
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_we    <= 1'b0;
            owner_q    <= OWNER_IF;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (grant_dm || grant_if) begin
                hold_addr  <= grant_dm ? dm_addr : if_addr;
                hold_wdata <= grant_dm ? dm_wdata : '0;
                hold_we    <= grant_dm & dm_we;
                owner_q    <= grant_dm ? OWNER_DM : OWNER_IF;
            end
            if (bus_done) begin
                // A timed-out transfer returns zero data, never the bus value
                err_q <= ~mem_rdy;
                if (owner_q == OWNER_DM) begin
                    dm_rdata_q <= mem_rdy ? mem_rdata : '0;
                end else begin
                    if_rdata_q <= mem_rdy ? mem_rdata : '0;
                end
            end
        end
    end

    // Consecutive DM grants while a fetch waits; an IF grant resets the run
    arb_sat_cnt #(
        .WIDTH (SW),
        .LIMIT (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .clr   (grant_if),
        .inc   (grant_dm & if_req),
        .cnt   (starve_cnt)
    );

    // Bus cycles spent waiting for mem_rdy in the current transfer
    arb_sat_cnt #(
        .WIDTH (TW),
        .LIMIT (TIMEOUT - 1)
    ) u_tmo_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .clr   (grant_dm | grant_if),
        .inc   (mem_req & ~mem_rdy),
        .cnt   (tmo_cnt)
    );

    // Memory side is driven purely from holding registers while on the bus
    assign mem_req   = (state == BUS_I) || (state == BUS_D);
    assign mem_we    = mem_req & hold_we;
    assign mem_addr  = hold_addr;
    assign mem_wdata = hold_wdata;

    // Requester responses: one-cycle ack in RESP to whichever side owns the port
    assign if_ack   = (state == RESP) && (owner_q == OWNER_IF);
    assign dm_ack   = (state == RESP) && (owner_q == OWNER_DM);
    assign err      = (state == RESP) & err_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign owner    = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arb
// Brief  : Directed self-checking bench for mem_port_arb: reset mid-transfer,
//          lone fetch, simultaneous requests, starvation and timeout.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arb;

    logic        clk;
    logic        clr_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdy;
    logic        owner;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arb #(
        .AW         (32),
        .DW         (32),
        .STARVE_MAX (4),
        .TIMEOUT    (15)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .owner     (owner),
        .err       (err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [5:0] grants;
        int         n_grant;
        int         bus_cycles;
        bit         got_ack;

        clr_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_rdy   = 1'b0;
        cycle();
        cycle();
        clr_n = 1'b1;
        cycle();

        // Reset state
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_owner",   {31'd0, owner},   32'd0);
        chk("rst_acks",    {30'd0, if_ack, dm_ack}, 32'd0);
        chk("rst_err",     {31'd0, err},     32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);

        // 1. Reset in the middle of a data transfer
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0040;
        dm_wdata = 32'h1234_5678;
        cycle();
        chk("t1_bus_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t1_bus_owner",   {31'd0, owner},   32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("t1_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t1_rst_mem_we",  {31'd0, mem_we},  32'd0);
        chk("t1_rst_acks",    {30'd0, if_ack, dm_ack}, 32'd0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        cycle();
        clr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_post_mem_req", {31'd0, mem_req}, 32'd0);
            chk("t1_post_acks",    {30'd0, if_ack, dm_ack}, 32'd0);
        end

        // 2. Lone fetch completing on the first bus cycle
        if_req    = 1'b1;
        if_addr   = 32'h0000_3000;
        mem_rdy   = 1'b1;
        mem_rdata = 32'h3C01_0001;
        cycle();
        chk("t2_mem_req",  {31'd0, mem_req}, 32'd1);
        chk("t2_mem_addr", mem_addr, 32'h0000_3000);
        chk("t2_mem_we",   {31'd0, mem_we},  32'd0);
        cycle();
        chk("t2_if_ack",   {31'd0, if_ack},  32'd1);
        chk("t2_dm_ack",   {31'd0, dm_ack},  32'd0);
        chk("t2_if_rdata", if_rdata, 32'h3C01_0001);
        chk("t2_err",      {31'd0, err},     32'd0);
        chk("t2_owner",    {31'd0, owner},   32'd0);
        chk("t2_resp_mem_req", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0;
        cycle();
        chk("t2_idle_ack", {30'd0, if_ack, dm_ack}, 32'd0);

        // 3. Simultaneous requests: store first, then the fetch
        if_req    = 1'b1;
        if_addr   = 32'h0000_3004;
        dm_req    = 1'b1;
        dm_we     = 1'b1;
        dm_addr   = 32'h0000_0004;
        dm_wdata  = 32'hA5A5_A5A5;
        mem_rdata = 32'h0BAD_F00D;
        cycle();
        chk("t3_d_mem_we",    {31'd0, mem_we}, 32'd1);
        chk("t3_d_mem_addr",  mem_addr, 32'h0000_0004);
        chk("t3_d_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("t3_d_owner",     {31'd0, owner}, 32'd1);
        cycle();
        chk("t3_d_acks", {30'd0, if_ack, dm_ack}, 32'd1);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        cycle();
        chk("t3_idle_mem_req", {31'd0, mem_req}, 32'd0);
        mem_rdata = 32'h2402_0005;
        cycle();
        chk("t3_i_mem_req",  {31'd0, mem_req}, 32'd1);
        chk("t3_i_mem_addr", mem_addr, 32'h0000_3004);
        chk("t3_i_mem_we",   {31'd0, mem_we}, 32'd0);
        chk("t3_i_owner",    {31'd0, owner},  32'd0);
        cycle();
        chk("t3_i_acks",   {30'd0, if_ack, dm_ack}, 32'd2);
        chk("t3_i_rdata",  if_rdata, 32'h2402_0005);
        if_req = 1'b0;
        cycle();

        // 4. Starvation: both requesting continuously -> D,D,D,D,I,D
        if_req  = 1'b1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0100;
        if_addr = 32'h0000_3008;
        grants  = '0;
        n_grant = 0;
        for (int i = 0; i < 40 && n_grant < 6; i++) begin
            cycle();
            if (mem_req) begin
                grants[n_grant] = owner;
                n_grant++;
            end
        end
        chk("t4_grant_count", n_grant, 32'd6);
        chk("t4_g0", {31'd0, grants[0]}, 32'd1);
        chk("t4_g1", {31'd0, grants[1]}, 32'd1);
        chk("t4_g2", {31'd0, grants[2]}, 32'd1);
        chk("t4_g3", {31'd0, grants[3]}, 32'd1);
        chk("t4_g4", {31'd0, grants[4]}, 32'd0);
        chk("t4_g5", {31'd0, grants[5]}, 32'd1);
        if_req = 1'b0;
        dm_req = 1'b0;
        cycle();
        cycle();
        chk("t4_idle_mem_req", {31'd0, mem_req}, 32'd0);

        // 5. Timeout: memory never ready
        dm_req     = 1'b1;
        dm_we      = 1'b0;
        dm_addr    = 32'h0000_0008;
        mem_rdy    = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
        bus_cycles = 0;
        got_ack    = 1'b0;
        for (int i = 0; i < 40 && !got_ack; i++) begin
            cycle();
            if (mem_req) begin
                bus_cycles++;
            end
            if (dm_ack || if_ack) begin
                got_ack = 1'b1;
            end
        end
        chk("t5_got_ack",    {31'd0, got_ack}, 32'd1);
        chk("t5_bus_cycles", bus_cycles, 32'd15);
        chk("t5_dm_ack",     {31'd0, dm_ack}, 32'd1);
        chk("t5_err",        {31'd0, err},    32'd1);
        chk("t5_rdata",      dm_rdata, 32'd0);
        dm_req = 1'b0;
        cycle();
        chk("t5_idle_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t5_idle_acks",    {30'd0, if_ack, dm_ack}, 32'd0);
        chk("t5_idle_err",     {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
